// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with EX/MEM and MEM/WB operand       |
// |               forwarding, WB-to-ID capture bypass and load-use detection.  |
// | Optional    : define ID_EX_STAT_EN for stat_bubbles / stat_flushes.        |
// | Revision    : 1.0                                                          |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [3:0]    id_aluop,
  input  logic          id_alusrc,
  input  logic          id_uses_rt,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          hazard_stall,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [3:0]    ex_aluop,
  output logic [RW-1:0] ex_rd,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite
`ifdef ID_EX_STAT_EN
  ,
  output logic [31:0]   stat_bubbles,
  output logic [31:0]   stat_flushes
`endif
);

  localparam logic [RW-1:0] c_zero_reg = '0;

  logic          r_valid;
  logic          r_regwrite;
  logic          r_memread;
  logic          r_memwrite;
  logic          r_alusrc;
  logic [3:0]    r_aluop;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_rs_val;
  logic [DW-1:0] r_rt_val;
  logic [DW-1:0] r_imm;

  logic          w_hazard;
  logic          w_bubble;
  logic          w_wb_hit_rs;
  logic          w_wb_hit_rt;
  logic [DW-1:0] w_rs_cap;
  logic [DW-1:0] w_rt_cap;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    w_hazard = 1'b0;
    if (!flush && r_valid && r_memread && (r_rd != c_zero_reg) && id_valid) begin
      if ((r_rd == id_rs) || (id_uses_rt && (r_rd == id_rt)))
        w_hazard = 1'b1;
    end
  end

  assign hazard_stall = w_hazard;
  assign w_bubble     = w_hazard && !stall;

  // Register file is written at the same edge ID reads it, so take WB data directly.
  assign w_wb_hit_rs = memwb_regwrite && (memwb_rd != c_zero_reg) && (memwb_rd == id_rs);
  assign w_wb_hit_rt = memwb_regwrite && (memwb_rd != c_zero_reg) && (memwb_rd == id_rt);
  assign w_rs_cap    = w_wb_hit_rs ? memwb_result : id_rs_val;
  assign w_rt_cap    = w_wb_hit_rt ? memwb_result : id_rt_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_rs_val   <= '0;
      r_rt_val   <= '0;
      r_imm      <= '0;
    end else if (flush || w_bubble) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (!stall) begin
      r_valid    <= id_valid;
      r_regwrite <= id_regwrite & id_valid;
      r_memread  <= id_memread & id_valid;
      r_memwrite <= id_memwrite & id_valid;
      r_alusrc   <= id_alusrc;
      r_aluop    <= id_aluop;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_rs_val   <= w_rs_cap;
      r_rt_val   <= w_rt_cap;
      r_imm      <= id_imm;
    end
  end

  // EX/MEM is newer than MEM/WB, so it wins; register 0 is never forwarded.
  always_comb begin
    w_fwd_rs = r_rs_val;
    if (exmem_regwrite && (exmem_rd != c_zero_reg) && (exmem_rd == r_rs))
      w_fwd_rs = exmem_result;
    else if (memwb_regwrite && (memwb_rd != c_zero_reg) && (memwb_rd == r_rs))
      w_fwd_rs = memwb_result;
  end

  always_comb begin
    w_fwd_rt = r_rt_val;
    if (exmem_regwrite && (exmem_rd != c_zero_reg) && (exmem_rd == r_rt))
      w_fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_rd != c_zero_reg) && (memwb_rd == r_rt))
      w_fwd_rt = memwb_result;
  end

  assign ex_a          = w_fwd_rs;
  assign ex_b          = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign ex_aluop      = r_aluop;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;

`ifdef ID_EX_STAT_EN
  logic [31:0] r_stat_bubbles;
  logic [31:0] r_stat_flushes;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_bubbles <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (flush)
        r_stat_flushes <= r_stat_flushes + 32'd1;
      if (!flush && w_bubble)
        r_stat_bubbles <= r_stat_bubbles + 32'd1;
    end
  end

  assign stat_bubbles = r_stat_bubbles;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Directed testbench for id_ex_stage: reset, forwarding, WB capture bypass,
// load-use bubble, flush/stall priority.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, id_valid;
  logic [DW-1:0] id_rs_val, id_rt_val, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [3:0]    id_aluop;
  logic          id_alusrc, id_uses_rt, id_regwrite, id_memread, id_memwrite;
  logic          exmem_regwrite, memwb_regwrite;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic          hazard_stall;
  logic [DW-1:0] ex_a, ex_b, ex_store_data;
  logic [3:0]    ex_aluop;
  logic [RW-1:0] ex_rd;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite;
`ifdef ID_EX_STAT_EN
  logic [31:0]   stat_bubbles, stat_flushes;
  int            exp_bubbles = 0;
  int            exp_flushes = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
`ifdef ID_EX_STAT_EN
    , .stat_bubbles(stat_bubbles), .stat_flushes(stat_flushes)
`endif
  );

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs_val = '0; id_rt_val = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_aluop = '0;
    id_alusrc = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0;
    id_memread = 1'b0; id_memwrite = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [DW-1:0] rsv,
                        input logic [RW-1:0] rt, input logic [DW-1:0] rtv,
                        input logic [DW-1:0] imm, input logic [RW-1:0] rd,
                        input logic [3:0] op, input logic src, input logic urt,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rs_val = rsv; id_rt = rt; id_rt_val = rtv;
    id_imm = imm; id_rd = rd; id_aluop = op; id_alusrc = src; id_uses_rt = urt;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  task automatic test_reset();
    set_id(1'b1, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 32'h77, 5'd9, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    vectors++;
    if ({ex_a, ex_b, ex_store_data} !== {3{32'h0}}) begin
      miscompares++;
      $display("FAIL reset_data got a=%h b=%h sd=%h want all 0", ex_a, ex_b, ex_store_data);
    end
    vectors++;
    if ({ex_aluop, ex_rd, ex_valid, ex_regwrite, ex_memread, ex_memwrite} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_ctl got op=%h rd=%h v=%b rw=%b mr=%b mw=%b want 0",
               ex_aluop, ex_rd, ex_valid, ex_regwrite, ex_memread, ex_memwrite);
    end
    vectors++;
    if (hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hazard got %b want 0", hazard_stall);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_forward();
    set_id(1'b1, 5'd5, 32'h55, 5'd6, 32'h66, 32'h0, 5'd7, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    vectors++;
    if (ex_a !== 32'h11) begin
      miscompares++; $display("FAIL fwd_exmem_prio ex_a got %h want 00000011", ex_a);
    end
    vectors++;
    if ({ex_b, ex_aluop, ex_rd, ex_valid, ex_regwrite} !== {32'h66, 4'd3, 5'd7, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL fwd_latched got b=%h op=%h rd=%h v=%b rw=%b want 66 3 07 1 1",
               ex_b, ex_aluop, ex_rd, ex_valid, ex_regwrite);
    end
    exmem_regwrite = 1'b0;
    #1;
    vectors++;
    if (ex_a !== 32'h22) begin
      miscompares++; $display("FAIL fwd_memwb ex_a got %h want 00000022", ex_a);
    end
    memwb_regwrite = 1'b0;
    #1;
    vectors++;
    if (ex_a !== 32'h55) begin
      miscompares++; $display("FAIL fwd_none ex_a got %h want 00000055", ex_a);
    end
    exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h77;
    #1;
    vectors++;
    if ({ex_b, ex_store_data} !== {32'h77, 32'h77}) begin
      miscompares++; $display("FAIL fwd_rt got b=%h sd=%h want 77 77", ex_b, ex_store_data);
    end
    // lui-style: immediate on b, store data still forwarded
    exmem_regwrite = 1'b0;
    set_id(1'b1, 5'd0, 32'h0, 5'd6, 32'h66, 32'h1000, 5'd2, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h77;
    #1;
    vectors++;
    if ({ex_b, ex_store_data, ex_aluop} !== {32'h1000, 32'h77, 4'b1010}) begin
      miscompares++;
      $display("FAIL alusrc_imm got b=%h sd=%h op=%h want 1000 77 a", ex_b, ex_store_data, ex_aluop);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reg_zero();
    set_id(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hEE;
    #1;
    vectors++;
    if ({ex_a, ex_store_data} !== 64'h0) begin
      miscompares++; $display("FAIL reg_zero got a=%h sd=%h want 0 0", ex_a, ex_store_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    // lw r8, 4(r1)
    set_id(1'b1, 5'd1, 32'h100, 5'd0, 32'h0, 32'h4, 5'd8, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    // reads r8 only through rt, but does not use rt
    set_id(1'b1, 5'd1, 32'h1, 5'd8, 32'h0, 32'h0, 5'd9, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if ({hazard_stall, ex_a, ex_b} !== {1'b0, 32'h100, 32'h4}) begin
      miscompares++;
      $display("FAIL hazard_no_rt got hz=%b a=%h b=%h want 0 100 4", hazard_stall, ex_a, ex_b);
    end
    // add r9, r8, r2
    set_id(1'b1, 5'd8, 32'h0, 5'd2, 32'h2, 32'h0, 5'd9, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    #1;
    vectors++;
    if (hazard_stall !== 1'b1) begin
      miscompares++; $display("FAIL hazard_detect got %b want 1", hazard_stall);
    end
    tick();
    vectors++;
    if ({ex_valid, ex_memread, hazard_stall} !== 3'b111) begin
      miscompares++;
      $display("FAIL stall_over_hazard got v=%b mr=%b hz=%b want 1 1 1", ex_valid, ex_memread, hazard_stall);
    end
    stall = 1'b0;
    tick();
`ifdef ID_EX_STAT_EN
    exp_bubbles++;
`endif
    vectors++;
    if ({ex_valid, ex_regwrite, ex_memread, hazard_stall} !== 4'b0000) begin
      miscompares++;
      $display("FAIL bubble got v=%b rw=%b mr=%b hz=%b want 0 0 0 0",
               ex_valid, ex_regwrite, ex_memread, hazard_stall);
    end
    exmem_regwrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'hABCD;
    tick();
    exmem_regwrite = 1'b0; exmem_rd = 5'd8; exmem_result = 32'h0;
    memwb_regwrite = 1'b1; memwb_rd = 5'd8; memwb_result = 32'hABCD;
    set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    vectors++;
    if ({ex_valid, ex_a, ex_b, ex_rd} !== {1'b1, 32'hABCD, 32'h2, 5'd9}) begin
      miscompares++;
      $display("FAIL after_bubble got v=%b a=%h b=%h rd=%h want 1 abcd 2 09", ex_valid, ex_a, ex_b, ex_rd);
    end
`ifdef ID_EX_STAT_EN
    vectors++;
    if (stat_bubbles !== exp_bubbles) begin
      miscompares++; $display("FAIL stat_bubbles got %0d want %0d", stat_bubbles, exp_bubbles);
    end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_wb_capture();
    set_id(1'b1, 5'd4, 32'h44, 5'd3, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h1234;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if ({ex_store_data, ex_a, ex_memwrite} !== {32'h1234, 32'h44, 1'b1}) begin
      miscompares++;
      $display("FAIL wb_capture_rt got sd=%h a=%h mw=%b want 1234 44 1", ex_store_data, ex_a, ex_memwrite);
    end
    set_id(1'b1, 5'd3, 32'h9, 5'd4, 32'h44, 32'h0, 5'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h5678;
    tick();
    idle_inputs();
    #1;
    vectors++;
    if ({ex_a, ex_store_data} !== {32'h5678, 32'h44}) begin
      miscompares++; $display("FAIL wb_capture_rs got a=%h sd=%h want 5678 44", ex_a, ex_store_data);
    end
    tick();
  endtask

  task automatic test_flush_stall();
    set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd8, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 32'h0, 5'd2, 32'h2, 32'h0, 5'd9, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; stall = 1'b1;
    #1;
    vectors++;
    if (hazard_stall !== 1'b0) begin
      miscompares++; $display("FAIL flush_masks_hazard got %b want 0", hazard_stall);
    end
    tick();
`ifdef ID_EX_STAT_EN
    exp_flushes++;
`endif
    flush = 1'b0; stall = 1'b0;
    set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    vectors++;
    if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite} !== 4'b0000) begin
      miscompares++;
      $display("FAIL flush_over_stall got v=%b rw=%b mr=%b mw=%b want 0 0 0 0",
               ex_valid, ex_regwrite, ex_memread, ex_memwrite);
    end
`ifdef ID_EX_STAT_EN
    vectors++;
    if (stat_flushes !== exp_flushes) begin
      miscompares++; $display("FAIL stat_flushes got %0d want %0d", stat_flushes, exp_flushes);
    end
`endif
    tick();
  endtask

  task automatic test_reset_pending();
    set_id(1'b1, 5'd1, 32'h1, 5'd0, 32'h0, 32'h0, 5'd8, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 32'h0, 5'd2, 32'h2, 32'h0, 5'd9, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    stall = 1'b1; rst_n = 1'b0;
    tick();
    vectors++;
    if ({ex_valid, ex_memread, ex_rd, ex_aluop, hazard_stall} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_over_stall got v=%b mr=%b rd=%h op=%h hz=%b want 0",
               ex_valid, ex_memread, ex_rd, ex_aluop, hazard_stall);
    end
`ifdef ID_EX_STAT_EN
    vectors++;
    if ({stat_bubbles, stat_flushes} !== 64'h0) begin
      miscompares++; $display("FAIL stat_reset got %0d %0d want 0 0", stat_bubbles, stat_flushes);
    end
`endif
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_forward();
    test_reg_zero();
    test_load_use();
    test_wb_capture();
    test_flush_stall();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
